// File: rtl/data_mem_ctrl.sv
// Data-memory stage: byte-addressed big-endian RAM behind a fixed-latency MOV/MOC handshake.
// Define DMEM_ALIGN_CHECK_EN to report misaligned accesses through addr_err instead of forcing alignment.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [31:0]       dout_q, dout_d;
  logic              moc_q, moc_d;
  logic              aerr_q, aerr_d;

  logic [7:0]        mem_q [DEPTH];

  logic              misalign_c;
  logic [1:0]        size_eff_c;
  logic [ADDR_W-1:0] a0_c, a1_c, a2_c, a3_c;
  logic [7:0]        b0_c, b1_c, b2_c, b3_c;
  logic [31:0]       rdata_c;
  logic              access_c;
  logic              wr_en_c;
  logic              unused_addr_hi;

  // Address bits above the array width wrap and carry no information.
  assign unused_addr_hi = ^addr[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment is judged on the live port values at the capture edge.
  assign misalign_c = ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                   || (size == SZ_RSVD);
  assign size_eff_c = req_q.size;
  assign a0_c       = req_q.addr;
`else
  assign misalign_c = 1'b0;
  assign size_eff_c = (req_q.size == SZ_RSVD) ? SZ_WORD : req_q.size;

  // Without the checker, halfword and word accesses silently drop their low address bits.
  always_comb begin
    a0_c = req_q.addr;
    case (size_eff_c)
      SZ_HALF: a0_c = {req_q.addr[ADDR_W-1:1], 1'b0};
      SZ_WORD: a0_c = {req_q.addr[ADDR_W-1:2], 2'b00};
      default: a0_c = req_q.addr;
    endcase
  end
`endif

  assign a1_c = a0_c + ADDR_W'(1);
  assign a2_c = a0_c + ADDR_W'(2);
  assign a3_c = a0_c + ADDR_W'(3);

  assign b0_c = mem_q[a0_c];
  assign b1_c = mem_q[a1_c];
  assign b2_c = mem_q[a2_c];
  assign b3_c = mem_q[a3_c];

  // Big-endian assembly: the lowest address holds the most significant byte.
  always_comb begin
    rdata_c = {b0_c, b1_c, b2_c, b3_c};
    case (size_eff_c)
      SZ_BYTE: rdata_c = {{24{req_q.sext & b0_c[7]}}, b0_c};
      SZ_HALF: rdata_c = {{16{req_q.sext & b0_c[7]}}, b0_c, b1_c};
      default: rdata_c = {b0_c, b1_c, b2_c, b3_c};
    endcase
  end

  assign access_c = (state_q == S_WAIT) && (cnt_q == '0);
  assign wr_en_c  = access_c && !req_q.rw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    aerr_d  = aerr_q;
    case (state_q)
      S_IDLE: begin
        if (mov) begin
          req_d.rw    = rw;
          req_d.size  = size;
          req_d.sext  = sign_ext;
          req_d.addr  = addr[ADDR_W-1:0];
          req_d.wdata = data_in;
          cnt_d       = CNT_W'(LATENCY - 1);
          if (misalign_c) begin
            state_d = S_DONE;
            moc_d   = 1'b1;
            aerr_d  = 1'b1;
            dout_d  = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          moc_d   = 1'b1;
          aerr_d  = 1'b0;
          if (req_q.rw) begin
            dout_d = rdata_c;
          end
        end
      end
      S_DONE: begin
        // Stay put while the CPU still holds mov; only one access per request.
        if (!mov) begin
          state_d = S_IDLE;
          moc_d   = 1'b0;
          aerr_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      aerr_q  <= aerr_d;
    end
  end

  // Array storage is deliberately not reset; reset only aborts the sequencer.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      case (size_eff_c)
        SZ_BYTE: begin
          mem_q[a0_c] <= req_q.wdata[7:0];
        end
        SZ_HALF: begin
          mem_q[a0_c] <= req_q.wdata[15:8];
          mem_q[a1_c] <= req_q.wdata[7:0];
        end
        default: begin
          mem_q[a0_c] <= req_q.wdata[31:24];
          mem_q[a1_c] <= req_q.wdata[23:16];
          mem_q[a2_c] <= req_q.wdata[15:8];
          mem_q[a3_c] <= req_q.wdata[7:0];
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign moc      = moc_q;
  assign addr_err = aerr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: scoreboard of expected load data, latency and error flag.
module tb_data_mem_ctrl;

  localparam int LAT = 3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mov = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    logic        aerr;
  } exp_t;

  exp_t sb_q[$];

  data_mem_ctrl #(.ADDR_W(9), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .mov      (mov),
    .rw       (rw),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc),
    .busy     (busy),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  // Drive one request; lat counts edges from the first edge with mov high until moc is seen (-1 on timeout).
  task automatic issue(input logic i_rw, input logic [1:0] i_size, input logic i_sext,
                       input logic [31:0] i_addr, input logic [31:0] i_data, input int hold,
                       output int lat, output logic [31:0] dout, output logic aerr,
                       output logic busy_cap, output logic hold_ok, output logic rel_ok);
    @(negedge clk);
    mov = 1'b1; rw = i_rw; size = i_size; sign_ext = i_sext; addr = i_addr; data_in = i_data;
    lat = -1;
    busy_cap = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy_cap = busy;
      if (moc === 1'b1) begin
        lat = n;
        break;
      end
    end
    dout = data_out;
    aerr = addr_err;
    hold_ok = 1'b1;
    for (int n = 0; n < hold; n++) begin
      @(posedge clk); #1;
      if (moc !== 1'b1 || busy !== 1'b1 || data_out !== dout) hold_ok = 1'b0;
    end
    @(negedge clk);
    mov = 1'b0; addr = 32'hFFFF_FFFF; data_in = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    rel_ok = (moc === 1'b0) && (busy === 1'b0) && (addr_err === 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (moc !== 1'b0) begin errors++; $display("FAIL reset_moc: got %b want 0", moc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_aerr: got %b want 0", addr_err); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 00000000", data_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] dout; logic aerr, bc, hk, rk; exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.lat = LAT + 1; e.aerr = 1'b0;
      e.data = (i == 0) ? 32'h0 : 32'hDEAD_BEEF;
      sb_q.push_back(e);
      if (i == 0) issue(1'b0, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, lat, dout, aerr, bc, hk, rk);
      else        issue(1'b1, SZ_W, 1'b0, 32'h10, 32'h0,         0, lat, dout, aerr, bc, hk, rk);
      e = sb_q.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL word_rw%0d_lat: got %0d want %0d", i, lat, e.lat); end
      checks++; if (dout !== e.data) begin errors++; $display("FAIL word_rw%0d_dout: got %h want %h", i, dout, e.data); end
      checks++; if (aerr !== e.aerr) begin errors++; $display("FAIL word_rw%0d_aerr: got %b want %b", i, aerr, e.aerr); end
      checks++; if (bc !== 1'b1) begin errors++; $display("FAIL word_rw%0d_busy_capture: got %b want 1", i, bc); end
      checks++; if (rk !== 1'b1) begin errors++; $display("FAIL word_rw%0d_release: got %b want 1", i, rk); end
    end
  endtask

  task automatic test_subword_loads();
    int lat; logic [31:0] dout; logic aerr, bc, hk, rk; exp_t e;
    logic [31:0] a; logic [1:0] sz; logic sx;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin a = 32'h011; sz = SZ_B; sx = 1'b1; e.data = 32'hFFFF_FFAD; end
        1:       begin a = 32'h211; sz = SZ_B; sx = 1'b0; e.data = 32'h0000_00AD; end
        2:       begin a = 32'h012; sz = SZ_H; sx = 1'b1; e.data = 32'hFFFF_BEEF; end
        default: begin a = 32'h012; sz = SZ_H; sx = 1'b0; e.data = 32'h0000_BEEF; end
      endcase
      e.lat = LAT + 1; e.aerr = 1'b0;
      sb_q.push_back(e);
      issue(1'b1, sz, sx, a, 32'h0, 0, lat, dout, aerr, bc, hk, rk);
      e = sb_q.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL subword%0d_lat: got %0d want %0d", i, lat, e.lat); end
      checks++; if (dout !== e.data) begin errors++; $display("FAIL subword%0d_dout: got %h want %h", i, dout, e.data); end
    end
  endtask

  task automatic test_byte_write_hold();
    int lat; logic [31:0] dout; logic aerr, bc, hk, rk; exp_t e;
    // Write leaves the previous load result in data_out.
    e.data = 32'h0000_BEEF; e.lat = LAT + 1; e.aerr = 1'b0;
    sb_q.push_back(e);
    issue(1'b0, SZ_B, 1'b0, 32'h13, 32'hFFFF_FF55, 0, lat, dout, aerr, bc, hk, rk);
    e = sb_q.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL bytewr_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL bytewr_retain: got %h want %h", dout, e.data); end
    e.data = 32'hDEAD_BE55; e.lat = LAT + 1; e.aerr = 1'b0;
    sb_q.push_back(e);
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'h0, 5, lat, dout, aerr, bc, hk, rk);
    e = sb_q.pop_front();
    checks++; if (dout !== e.data) begin errors++; $display("FAIL hold_dout: got %h want %h", dout, e.data); end
    checks++; if (hk !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b want 1", hk); end
    checks++; if (rk !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", rk); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] dout; logic aerr, bc, hk, rk; exp_t e;
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; size = SZ_W; sign_ext = 1'b0; addr = 32'h10; data_in = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1; mov = 1'b0;
    #1;
    checks++; if (moc !== 1'b0) begin errors++; $display("FAIL abort_moc: got %b want 0", moc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL abort_aerr: got %b want 0", addr_err); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL abort_dout: got %h want 00000000", data_out); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    e.data = 32'hDEAD_BE55; e.lat = LAT + 1; e.aerr = 1'b0;
    sb_q.push_back(e);
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'h0, 0, lat, dout, aerr, bc, hk, rk);
    e = sb_q.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL abort_read_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL abort_read_dout: got %h want %h", dout, e.data); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] dout; logic aerr, bc, hk, rk; exp_t e;
`ifdef DMEM_ALIGN_CHECK_EN
    e.data = 32'h0; e.lat = 1; e.aerr = 1'b1;
`else
    e.data = 32'hDEAD_BE55; e.lat = LAT + 1; e.aerr = 1'b0;
`endif
    sb_q.push_back(e);
    issue(1'b1, SZ_W, 1'b0, 32'h12, 32'h0, 2, lat, dout, aerr, bc, hk, rk);
    e = sb_q.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL misalign_lat: got %0d want %0d", lat, e.lat); end
    checks++; if (dout !== e.data) begin errors++; $display("FAIL misalign_dout: got %h want %h", dout, e.data); end
    checks++; if (aerr !== e.aerr) begin errors++; $display("FAIL misalign_aerr: got %b want %b", aerr, e.aerr); end
    checks++; if (hk !== 1'b1) begin errors++; $display("FAIL misalign_hold: got %b want 1", hk); end
    checks++; if (rk !== 1'b1) begin errors++; $display("FAIL misalign_release: got %b want 1", rk); end
    e.data = 32'hDEAD_BE55; e.lat = LAT + 1; e.aerr = 1'b0;
    sb_q.push_back(e);
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'h0, 0, lat, dout, aerr, bc, hk, rk);
    e = sb_q.pop_front();
    checks++; if (dout !== e.data) begin errors++; $display("FAIL misalign_mem_dout: got %h want %h", dout, e.data); end
    checks++; if (aerr !== e.aerr) begin errors++; $display("FAIL misalign_mem_aerr: got %b want %b", aerr, e.aerr); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword_loads();
    test_byte_write_hold();
    test_reset_abort();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
